// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman feeder: base encoding, default
// sequence geometry, score/position widths and the feeder state type.
package sw_pkg;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_C = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_T = 2'd3;

  localparam int LEN_REF_DEF         = 64;
  localparam int LEN_QUERY_DEF       = 48;
  localparam int BASES_PER_WORD_DEF  = 8;
  localparam int WIDTH_SCORE_DEF     = 8;
  localparam int WIDTH_POS_REF_DEF   = 7;
  localparam int WIDTH_POS_QUERY_DEF = 6;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2
  } sw_state_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_base_buffer.sv
// Word-write / base-read register file holding one packed 2-bit sequence.
// Words are written whole; any single base is read back combinationally.
module sw_base_buffer
  import sw_pkg::*;
#(
  parameter int NUM_BASES = 64,
  parameter int BPW       = 8,
  localparam int NUM_WORDS = NUM_BASES / BPW,
  localparam int WA_W      = clog2_min1(NUM_WORDS),
  localparam int BA_W      = clog2_min1(NUM_BASES),
  localparam int OFF_W     = clog2_min1(BPW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [WA_W-1:0]    waddr,
  input  logic [2*BPW-1:0]   wdata,
  input  logic [BA_W-1:0]    raddr,
  output logic [1:0]         base
);

  logic [2*BPW-1:0] mem_q [NUM_WORDS];
  logic [2*BPW-1:0] mem_d [NUM_WORDS];
  logic [2*BPW-1:0] word_sel;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Upper address bits pick the word, lower bits pick the base (LSB base first).
  assign word_sel = mem_q[raddr[BA_W-1:OFF_W]];
  assign base     = word_sel[{raddr[OFF_W-1:0], 1'b0} +: 2];

endmodule

// File: rtl/sw_seq_feeder.sv
// Upstream feeder for the Smith-Waterman core: buffers one reference/query
// pair from the host, replays it as a 2-bit stream, then captures the result.
module sw_seq_feeder
  import sw_pkg::*;
#(
  parameter int LEN_REF         = LEN_REF_DEF,
  parameter int LEN_QUERY       = LEN_QUERY_DEF,
  parameter int BASES_PER_WORD  = BASES_PER_WORD_DEF,
  parameter int WIDTH_SCORE     = WIDTH_SCORE_DEF,
  parameter int WIDTH_POS_REF   = WIDTH_POS_REF_DEF,
  parameter int WIDTH_POS_QUERY = WIDTH_POS_QUERY_DEF,
  parameter int TIMEOUT         = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*BASES_PER_WORD-1:0]  in_data,
  output logic                         sw_valid,
  output logic [1:0]                   sw_data_ref,
  output logic [1:0]                   sw_data_query,
  input  logic                         sw_finish,
  input  logic [WIDTH_SCORE-1:0]       sw_max,
  input  logic [WIDTH_POS_REF-1:0]     sw_pos_ref,
  input  logic [WIDTH_POS_QUERY-1:0]   sw_pos_query,
  output logic                         res_valid,
  output logic [WIDTH_SCORE-1:0]       res_max,
  output logic [WIDTH_POS_REF-1:0]     res_pos_ref,
  output logic [WIDTH_POS_QUERY-1:0]   res_pos_query,
  output logic                         timeout_err,
  output logic                         busy
);

  localparam int NW_REF   = LEN_REF / BASES_PER_WORD;
  localparam int NW_QUERY = LEN_QUERY / BASES_PER_WORD;
  localparam int NW       = NW_REF + NW_QUERY;
  localparam int WC_W     = clog2_min1(NW + 1);
  localparam int BC_W     = clog2_min1(LEN_REF);
  localparam int QB_W     = clog2_min1(LEN_QUERY);
  localparam int RWA_W    = clog2_min1(NW_REF);
  localparam int QWA_W    = clog2_min1(NW_QUERY);
  localparam int WD_W     = clog2_min1(TIMEOUT + 1);

  sw_state_e            state_q, state_d;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]      base_cnt_q, base_cnt_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 in_ready_q, in_ready_d;
  logic                 sw_valid_q, sw_valid_d;
  logic [1:0]           sw_data_ref_q, sw_data_ref_d;
  logic [1:0]           sw_data_query_q, sw_data_query_d;
  logic                 res_valid_q, res_valid_d;
  logic [WIDTH_SCORE-1:0]     res_max_q, res_max_d;
  logic [WIDTH_POS_REF-1:0]   res_pos_ref_q, res_pos_ref_d;
  logic [WIDTH_POS_QUERY-1:0] res_pos_query_q, res_pos_query_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic                 ref_we, query_we;
  logic [RWA_W-1:0]     ref_waddr;
  logic [QWA_W-1:0]     query_waddr;
  logic                 query_in_range;
  logic [QB_W-1:0]      query_raddr;
  logic [1:0]           ref_base, query_base;

  assign accept      = in_valid && in_ready_q;
  assign ref_we      = accept && (word_cnt_q < WC_W'(NW_REF));
  assign query_we    = accept && !(word_cnt_q < WC_W'(NW_REF));
  assign ref_waddr   = RWA_W'(word_cnt_q);
  assign query_waddr = QWA_W'(word_cnt_q - WC_W'(NW_REF));

  sw_base_buffer #(.NUM_BASES(LEN_REF), .BPW(BASES_PER_WORD)) u_ref_buf (
    .clk   (clk),
    .reset (reset),
    .we    (ref_we),
    .waddr (ref_waddr),
    .wdata (in_data),
    .raddr (base_cnt_d),
    .base  (ref_base)
  );

  sw_base_buffer #(.NUM_BASES(LEN_QUERY), .BPW(BASES_PER_WORD)) u_query_buf (
    .clk   (clk),
    .reset (reset),
    .we    (query_we),
    .waddr (query_waddr),
    .wdata (in_data),
    .raddr (query_raddr),
    .base  (query_base)
  );

  // Outputs are registered, so the stream data is fetched at the next base index.
  assign query_in_range = ({1'b0, base_cnt_d} < (BC_W + 1)'(LEN_QUERY));
  assign query_raddr    = query_in_range ? QB_W'(base_cnt_d) : '0;

  always_comb begin
    state_d         = state_q;
    word_cnt_d      = word_cnt_q;
    base_cnt_d      = base_cnt_q;
    wdog_d          = wdog_q;
    res_valid_d     = 1'b0;
    res_max_d       = res_max_q;
    res_pos_ref_d   = res_pos_ref_q;
    res_pos_query_d = res_pos_query_q;
    timeout_err_d   = timeout_err_q;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (word_cnt_q == WC_W'(NW - 1)) begin
            state_d    = STREAM;
            word_cnt_d = '0;
            base_cnt_d = '0;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (base_cnt_q == BC_W'(LEN_REF - 1)) begin
          state_d = WAIT;
          wdog_d  = '0;
        end else begin
          base_cnt_d = base_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        // A finish on the expiry cycle takes priority over the watchdog.
        if (sw_finish) begin
          res_valid_d     = 1'b1;
          res_max_d       = sw_max;
          res_pos_ref_d   = sw_pos_ref;
          res_pos_query_d = sw_pos_query;
          state_d         = LOAD;
          wdog_d          = '0;
        end else if (wdog_q == WD_W'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          state_d       = LOAD;
          wdog_d        = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d      = (state_d == LOAD) && (word_cnt_d < WC_W'(NW));
    sw_valid_d      = (state_d == STREAM);
    sw_data_ref_d   = sw_valid_d ? ref_base : BASE_A;
    sw_data_query_d = (sw_valid_d && query_in_range) ? query_base : BASE_A;
    busy_d          = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= LOAD;
      word_cnt_q      <= '0;
      base_cnt_q      <= '0;
      wdog_q          <= '0;
      in_ready_q      <= 1'b0;
      sw_valid_q      <= 1'b0;
      sw_data_ref_q   <= '0;
      sw_data_query_q <= '0;
      res_valid_q     <= 1'b0;
      res_max_q       <= '0;
      res_pos_ref_q   <= '0;
      res_pos_query_q <= '0;
      timeout_err_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      base_cnt_q      <= base_cnt_d;
      wdog_q          <= wdog_d;
      in_ready_q      <= in_ready_d;
      sw_valid_q      <= sw_valid_d;
      sw_data_ref_q   <= sw_data_ref_d;
      sw_data_query_q <= sw_data_query_d;
      res_valid_q     <= res_valid_d;
      res_max_q       <= res_max_d;
      res_pos_ref_q   <= res_pos_ref_d;
      res_pos_query_q <= res_pos_query_d;
      timeout_err_q   <= timeout_err_d;
      busy_q          <= busy_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign sw_valid      = sw_valid_q;
  assign sw_data_ref   = sw_data_ref_q;
  assign sw_data_query = sw_data_query_q;
  assign res_valid     = res_valid_q;
  assign res_max       = res_max_q;
  assign res_pos_ref   = res_pos_ref_q;
  assign res_pos_query = res_pos_query_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Scoreboard bench for sw_seq_feeder: stimulus pushes expected stream beats
// and results into queues, a monitor pops and compares whenever the DUT emits.
module tb_sw_seq_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sw_valid;
  logic [1:0]  sw_data_ref;
  logic [1:0]  sw_data_query;
  logic        sw_finish;
  logic [7:0]  sw_max;
  logic [6:0]  sw_pos_ref;
  logic [5:0]  sw_pos_query;
  logic        res_valid;
  logic [7:0]  res_max;
  logic [6:0]  res_pos_ref;
  logic [5:0]  res_pos_query;
  logic        timeout_err;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;
  int beat_no  = 0;

  logic [3:0]  exp_beats [$];
  logic [20:0] exp_results [$];

  always #5 clk = ~clk;

  sw_seq_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .sw_valid      (sw_valid),
    .sw_data_ref   (sw_data_ref),
    .sw_data_query (sw_data_query),
    .sw_finish     (sw_finish),
    .sw_max        (sw_max),
    .sw_pos_ref    (sw_pos_ref),
    .sw_pos_query  (sw_pos_query),
    .res_valid     (res_valid),
    .res_max       (res_max),
    .res_pos_ref   (res_pos_ref),
    .res_pos_query (res_pos_query),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Hand-derived streams. Pattern 0: ref words 1B1B -> 3,2,1,0 ; query E4E4 -> 0,1,2,3.
  // Pattern 1: every word holds one repeated base, so the value tracks the word index.
  function automatic logic [3:0] exp_beat(input int pat, input int k);
    logic [1:0] r;
    logic [1:0] q;
    if (pat == 0) begin
      r = 2'(3 - (k % 4));
      q = (k < 48) ? 2'(k % 4) : 2'd0;
    end else begin
      r = 2'((k / 8) % 4);
      q = (k < 48) ? 2'(3 - ((k / 8) % 4)) : 2'd0;
    end
    return {r, q};
  endfunction

  task automatic applyStimulus(input int pat, input bit gaps, input int n_beats, output int cycles);
    logic [15:0] words [14];
    logic [15:0] solid [4];
    int idx;
    bit v;
    solid = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF};
    for (int i = 0; i < 14; i++) begin
      if (pat == 0) words[i] = (i < 8) ? 16'h1B1B : 16'hE4E4;
      else          words[i] = (i < 8) ? solid[i % 4] : solid[3 - ((i - 8) % 4)];
    end
    for (int k = 0; k < n_beats; k++) exp_beats.push_back(exp_beat(pat, k));
    idx    = 0;
    cycles = 0;
    while (idx < 14 && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      v        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? words[idx] : 16'h0000;
      if (v && in_ready) idx++;
    end
    checkOutput("words_accepted", idx, 14);
  endtask

  task automatic wait_stream(input int exp_len, input bit hold_valid, input string tag);
    int len;
    int ready_hits;
    len        = 0;
    ready_hits = 0;
    @(negedge clk);
    in_valid = hold_valid;
    in_data  = 16'hFFFF;
    checkOutput({tag, "_stream_start"}, sw_valid, 1);
    while (sw_valid && len < 500) begin
      len++;
      if (in_ready) ready_hits++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput({tag, "_stream_len"}, len, exp_len);
    checkOutput({tag, "_ready_in_stream"}, ready_hits, 0);
  endtask

  task automatic finish_after(input int delay, input logic [20:0] res, input logic exp_err, input string tag);
    repeat (delay) @(negedge clk);
    checkOutput({tag, "_busy_waiting"}, busy, 1);
    {sw_max, sw_pos_ref, sw_pos_query} = res;
    sw_finish = 1'b1;
    exp_results.push_back(res);
    @(negedge clk);
    sw_finish = 1'b0;
    {sw_max, sw_pos_ref, sw_pos_query} = 21'h15A5A5;
    checkOutput({tag, "_res_pulse"}, res_valid, 1);
    checkOutput({tag, "_busy_done"}, busy, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err, exp_err);
    @(negedge clk);
    checkOutput({tag, "_res_single"}, res_valid, 0);
    checkOutput({tag, "_ready_after"}, in_ready, 1);
    checkOutput({tag, "_res_held"}, {res_max, res_pos_ref, res_pos_query}, res);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ctrl_zero"}, {in_ready, sw_valid, res_valid, timeout_err, busy}, 0);
    checkOutput({tag, "_data_zero"}, {sw_data_ref, sw_data_query}, 0);
    checkOutput({tag, "_res_zero"}, {res_max, res_pos_ref, res_pos_query}, 0);
  endtask

  // Monitor: consume one expected beat per valid stream cycle and one result per pulse.
  initial begin
    logic [3:0]  e;
    logic [20:0] r;
    forever begin
      @(negedge clk);
      if (sw_valid) begin
        checkOutput("beat_expected", exp_beats.size() > 0, 1);
        if (exp_beats.size() > 0) begin
          e = exp_beats.pop_front();
          checkOutput($sformatf("beat%0d", beat_no), {sw_data_ref, sw_data_query}, e);
        end
        beat_no++;
      end else begin
        beat_no = 0;
      end
      if (res_valid) begin
        checkOutput("result_expected", exp_results.size() > 0, 1);
        if (exp_results.size() > 0) begin
          r = exp_results.pop_front();
          checkOutput("result_value", {res_max, res_pos_ref, res_pos_query}, r);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    int cyc;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = 16'h0000;
    sw_finish    = 1'b0;
    sw_max       = 8'd0;
    sw_pos_ref   = 7'd0;
    sw_pos_query = 6'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    reset = 1'b0;

    $display("[TB] scenario 1: contiguous load of 1B1B/E4E4, in_valid held");
    applyStimulus(0, 1'b0, 64, cyc);
    checkOutput("s1_ready_cycles", cyc, 14);
    wait_stream(64, 1'b1, "s1");

    $display("[TB] scenario 3: finish 200 cycles into WAIT");
    finish_after(200, {8'd37, 7'd50, 6'd40}, 1'b0, "s3");

    $display("[TB] sw_finish in LOAD is ignored");
    sw_finish = 1'b1;
    {sw_max, sw_pos_ref, sw_pos_query} = {8'd99, 7'd1, 6'd2};
    @(negedge clk);
    @(negedge clk);
    sw_finish = 1'b0;
    checkOutput("load_finish_no_pulse", res_valid, 0);
    checkOutput("load_finish_res_held", res_max, 37);

    $display("[TB] scenario 2: load with random in_valid gaps");
    applyStimulus(0, 1'b1, 64, cyc);
    wait_stream(64, 1'b0, "s2");
    finish_after(5, {8'd200, 7'd127, 6'd0}, 1'b0, "s2");

    $display("[TB] scenario 4: core never finishes");
    applyStimulus(1, 1'b0, 64, cyc);
    wait_stream(64, 1'b0, "s4");
    repeat (1023) @(negedge clk);
    checkOutput("s4_no_err_before_expiry", timeout_err, 0);
    checkOutput("s4_busy_before_expiry", busy, 1);
    @(negedge clk);
    checkOutput("s4_timeout_err", timeout_err, 1);
    checkOutput("s4_ready_after", in_ready, 1);
    checkOutput("s4_busy_after", busy, 0);
    checkOutput("s4_no_res_pulse", res_valid, 0);
    repeat (5) @(negedge clk);
    checkOutput("s4_err_sticky", timeout_err, 1);

    $display("[TB] scenario 5: reset at stream cycle 20");
    applyStimulus(1, 1'b0, 21, cyc);
    @(negedge clk);
    checkOutput("s5_stream_start", sw_valid, 1);
    checkOutput("s5_err_still_set", timeout_err, 1);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("s5");
    reset = 1'b0;
    applyStimulus(0, 1'b0, 64, cyc);
    wait_stream(64, 1'b0, "s5b");

    $display("[TB] scenario 6: finish exactly at watchdog expiry");
    finish_after(1023, {8'd18, 7'd63, 6'd47}, 1'b0, "s6");

    repeat (3) @(negedge clk);
    checkOutput("beats_left", exp_beats.size(), 0);
    checkOutput("results_left", exp_results.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
